// File: rtl/uk101_ascii_loader_if.sv
// Interface between the HPS download port, the loader and the ACIA receive path.
// master drives the download bytes and the receive handshake; slave is the loader.
interface uk101_ascii_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic        enable;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        busy;
  logic        overflow;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, enable, rx_ready,
    input  ioctl_wait, rx_data, rx_valid, busy, overflow
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, enable, rx_ready,
    output ioctl_wait, rx_data, rx_valid, busy, overflow
  );
endinterface

// File: rtl/uk101_ascii_loader.sv
// Buffers a downloaded text file, normalises line endings and feeds it to the ACIA
// receive path one character at a time with a pacing gap after each character.
module uk101_ascii_loader #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CHAR_GAP = 52083,
  parameter int unsigned CR_GAP   = 2500000
) (
  input logic                 clk_sys,
  input logic                 reset,
  uk101_ascii_loader_if.slave bus
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned GapMax = (CR_GAP > CHAR_GAP) ? CR_GAP : CHAR_GAP;
  localparam int unsigned GW     = $clog2(GapMax + 1);

  localparam logic [AW:0]   PtrOne   = (AW + 1)'(1);
  localparam logic [AW:0]   FullCnt  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   WaitCnt  = (AW + 1)'(DEPTH - 2);
  localparam logic [GW-1:0] GapOne   = GW'(1);
  localparam logic [GW-1:0] CharLoad = GW'(CHAR_GAP - 1);
  localparam logic [GW-1:0] CrLoad   = GW'(CR_GAP - 1);

  typedef enum logic [1:0] {StIdle, StPresent, StGap} state_e;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          prev_cr_q, prev_cr_d;
  logic          overflow_q, overflow_d;
  logic          wait_q;
  logic          dl_q;
  state_e        state_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic [GW-1:0] gap_cnt_q;

  logic          dl_rise, ingest, prev_cr_eff, drop, push_req, push_ok, pop;
  logic          empty, full_eff;
  logic [7:0]    push_byte;
  logic [AW-1:0] push_idx;
  logic          unused_addr;

  assign unused_addr = ^bus.ioctl_addr;

  assign dl_rise     = bus.ioctl_download & ~dl_q;
  assign ingest      = bus.ioctl_download & bus.ioctl_wr;
  // A download start clears prev_cr in the same cycle as a possible first strobe.
  assign prev_cr_eff = dl_rise ? 1'b0 : prev_cr_q;
  assign drop        = (bus.ioctl_data == 8'h00) || (bus.ioctl_data == 8'h1A) ||
                       ((bus.ioctl_data == 8'h0A) && prev_cr_eff);
  assign push_byte   = (bus.ioctl_data == 8'h0A) ? 8'h0D : bus.ioctl_data;
  assign push_req    = ingest & ~drop;

  assign empty    = (count_q == '0);
  assign full_eff = ~dl_rise & (count_q == FullCnt);
  assign pop      = (state_q == StIdle) & bus.enable & ~empty & ~dl_rise;
  assign push_ok  = push_req & (~full_eff | pop);
  assign push_idx = dl_rise ? '0 : wr_ptr_q[AW-1:0];

  always_comb begin
    wr_ptr_d = dl_rise ? '0 : wr_ptr_q;
    rd_ptr_d = dl_rise ? '0 : rd_ptr_q;
    count_d  = dl_rise ? '0 : count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_d + PtrOne;
      count_d  = count_d + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
      count_d  = count_d - PtrOne;
    end
    overflow_d = dl_rise ? 1'b0 : (overflow_q | (push_req & ~push_ok));
    if (ingest) begin
      prev_cr_d = (bus.ioctl_data == 8'h0D);
    end else begin
      prev_cr_d = prev_cr_eff;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem[push_idx] <= push_byte;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      prev_cr_q  <= 1'b0;
      overflow_q <= 1'b0;
      wait_q     <= 1'b0;
      dl_q       <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      prev_cr_q  <= prev_cr_d;
      overflow_q <= overflow_d;
      wait_q     <= (count_q >= WaitCnt);
      dl_q       <= bus.ioctl_download;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StIdle;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            rx_data_q  <= mem[rd_ptr_q[AW-1:0]];
            rx_valid_q <= 1'b1;
            state_q    <= StPresent;
          end
        end
        StPresent: begin
          if (bus.rx_ready) begin
            rx_valid_q <= 1'b0;
            gap_cnt_q  <= (rx_data_q == 8'h0D) ? CrLoad : CharLoad;
            state_q    <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q - GapOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = bus.ioctl_download | ~empty | (state_q != StIdle);

endmodule

// File: tb/tb_uk101_ascii_loader.sv
// Self-checking bench: table vectors, directed FIFO/reset corners and a randomized
// stream checked against a text-translation model.
module tb_uk101_ascii_loader;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned CHAR_GAP = 4;
  localparam int unsigned CR_GAP   = 10;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  uk101_ascii_loader_if bus();

  uk101_ascii_loader #(
    .DEPTH    (DEPTH),
    .CHAR_GAP (CHAR_GAP),
    .CR_GAP   (CR_GAP)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rand_ready = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receive-side monitor: record each rx_valid rise and check data holds until accepted.
  logic [7:0] got_data[$];
  int         got_rise[$];
  logic       v_prev  = 1'b0;
  logic       hs_prev = 1'b0;
  logic [7:0] d_prev  = 8'h00;

  always @(negedge clk_sys) begin
    if (bus.rx_valid && !v_prev) begin
      got_data.push_back(bus.rx_data);
      got_rise.push_back(cyc);
    end
    if (bus.rx_valid && v_prev && !hs_prev) check("rx_data_stable", bus.rx_data, d_prev);
    v_prev  = bus.rx_valid;
    hs_prev = bus.rx_valid & bus.rx_ready;
    d_prev  = bus.rx_data;
  end

  // Reference model: the file-to-terminal text translation.
  logic [7:0] exp_q[$];
  logic       m_pcr;

  function automatic void model_ingest(input logic [7:0] b);
    if (b == 8'h0A) begin
      if (!m_pcr) exp_q.push_back(8'h0D);
    end else if (b != 8'h00 && b != 8'h1A) begin
      exp_q.push_back(b);
    end
    m_pcr = (b == 8'h0D);
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (rand_ready) bus.rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_data = b;
    bus.ioctl_addr = 16'($urandom);
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic start_section();
    got_data.delete();
    got_rise.delete();
    exp_q.delete();
    m_pcr = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while ((got_data.size() < n || bus.busy) && k < budget) begin
      tick();
      k++;
    end
    check("done_within_budget", 32'(k < budget), 1);
  endtask

  task automatic compare_seq(input string name);
    check({name, "_len"}, got_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      check(name, got_data[i], exp_q[i]);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h0A;
      2: return 8'h0D;
      3: return 8'h1A;
      default: return 8'($urandom_range(8'h20, 8'h7E));
    endcase
  endfunction

  typedef struct {
    logic [7:0] in_b [8];
    int         n_in;
    logic [7:0] exp_b [8];
    int         n_exp;
  } vec_t;

  vec_t vt [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int n_str;
    int len;
    bit saw_valid;
    logic [7:0] b;

    vt[0].in_b = '{8'h41, 8'h42, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[0].n_in = 4;
    vt[0].exp_b = '{8'h41, 8'h42, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[0].n_exp = 3;
    vt[1].in_b = '{8'h58, 8'h0A, 8'h59, 8'h00, 8'h5A, 8'h1A, 8'h00, 8'h00};
    vt[1].n_in = 6;
    vt[1].exp_b = '{8'h58, 8'h0D, 8'h59, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[1].n_exp = 4;
    vt[2].in_b = '{8'h0D, 8'h0D, 8'h0A, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[2].n_in = 4;
    vt[2].exp_b = '{8'h0D, 8'h0D, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[2].n_exp = 3;
    vt[3].in_b = '{8'h0D, 8'h00, 8'h0A, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[3].n_in = 4;
    vt[3].exp_b = '{8'h0D, 8'h0D, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[3].n_exp = 3;
    vt[4].in_b = '{8'h51, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[4].n_in = 2;
    vt[4].exp_b = '{8'h51, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[4].n_exp = 2;
    // Follows a file ending in CR: the new download must clear prev_cr.
    vt[5].in_b = '{8'h0A, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[5].n_in = 2;
    vt[5].exp_b = '{8'h0D, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[5].n_exp = 2;

    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 16'h0000;
    bus.ioctl_data     = 8'h00;
    bus.enable         = 1'b0;
    bus.rx_ready       = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_ioctl_wait", bus.ioctl_wait, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    tick();

    // Table vectors with back-to-back consumer; checks data and rise-to-rise pacing.
    for (int v = 0; v < 6; v++) begin
      start_section();
      for (int i = 0; i < vt[v].n_exp; i++) exp_q.push_back(vt[v].exp_b[i]);
      bus.enable         = 1'b1;
      bus.rx_ready       = 1'b1;
      bus.ioctl_download = 1'b1;
      for (int i = 0; i < vt[v].n_in; i++) strobe(vt[v].in_b[i]);
      bus.ioctl_download = 1'b0;
      wait_done(vt[v].n_exp, 400);
      compare_seq($sformatf("vec%0d_data", v));
      for (int i = 1; i < got_rise.size() && i < vt[v].n_exp; i++) begin
        check($sformatf("vec%0d_rise_gap%0d", v, i), got_rise[i] - got_rise[i-1],
              ((vt[v].exp_b[i-1] == 8'h0D) ? CR_GAP : CHAR_GAP) + 2);
      end
    end

    // Hold enable low during download; nothing may appear until it rises.
    start_section();
    bus.enable         = 1'b0;
    bus.rx_ready       = 1'b1;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = rand_byte();
      model_ingest(b);
      strobe(b);
    end
    bus.ioctl_download = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.rx_valid) saw_valid = 1'b1;
    end
    check("hold_no_rx_valid", saw_valid, 0);
    check("hold_busy_buffered", bus.busy, (exp_q.size() != 0) ? 1 : 0);
    bus.enable = 1'b1;
    wait_done(exp_q.size(), 400);
    compare_seq("hold_data");

    // Back-pressure and overflow with the output stalled.
    start_section();
    bus.enable         = 1'b0;
    bus.rx_ready       = 1'b0;
    bus.ioctl_download = 1'b1;
    n_str = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.ioctl_wait) break;
      strobe(8'(8'h30 + k));
      n_str++;
    end
    check("wait_strobes_accepted", n_str, DEPTH - 1);
    repeat (3) tick();
    check("wait_honoured_no_overflow", bus.overflow, 0);
    for (int k = 0; k < 3; k++) strobe(8'(8'h30 + n_str + k));
    check("forced_overflow", bus.overflow, 1);
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(8'(8'h30 + k));
    bus.ioctl_download = 1'b0;
    bus.enable         = 1'b1;
    bus.rx_ready       = 1'b1;
    wait_done(DEPTH, 600);
    compare_seq("full_drain");
    check("wait_released", bus.ioctl_wait, 0);
    check("overflow_sticky", bus.overflow, 1);
    bus.ioctl_download = 1'b1;
    tick();
    check("overflow_cleared_on_start", bus.overflow, 0);

    // Simultaneous push and pop on a full FIFO.
    start_section();
    bus.enable   = 1'b0;
    bus.rx_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) strobe(8'(8'h60 + k));
    check("fill_no_overflow", bus.overflow, 0);
    bus.enable = 1'b1;
    strobe(8'h70);
    check("pushpop_no_overflow", bus.overflow, 0);
    check("pushpop_wait_held", bus.ioctl_wait, 1);
    // Still full: one more push must be lost.
    strobe(8'h71);
    check("pushpop_count_full", bus.overflow, 1);
    for (int k = 0; k <= DEPTH; k++) exp_q.push_back(8'(8'h60 + k));
    bus.ioctl_download = 1'b0;
    bus.rx_ready       = 1'b1;
    wait_done(DEPTH + 1, 600);
    compare_seq("pushpop_order");

    // Reset in the middle of a gap with five bytes buffered.
    start_section();
    bus.enable         = 1'b1;
    bus.rx_ready       = 1'b1;
    bus.ioctl_download = 1'b1;
    for (int k = 0; k < 6; k++) strobe(8'(8'h41 + k));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midgap_rst_rx_valid", bus.rx_valid, 0);
    check("midgap_rst_rx_data", bus.rx_data, 0);
    check("midgap_rst_overflow", bus.overflow, 0);
    check("midgap_rst_busy", bus.busy, bus.ioctl_download);
    bus.ioctl_download = 1'b0;
    tick();
    check("midgap_busy_after", bus.busy, 0);
    repeat (30) tick();
    check("midgap_data_discarded", got_data.size(), 1);

    // Randomized streams against the translation model, random consumer readiness.
    for (int r = 0; r < 4; r++) begin
      start_section();
      bus.enable         = 1'b1;
      rand_ready         = 1'b1;
      bus.ioctl_download = 1'b1;
      len = $urandom_range(10, 40);
      for (int i = 0; i < len; i++) begin
        for (int k = 0; k < 2000 && bus.ioctl_wait; k++) tick();
        if ($urandom_range(0, 2) == 0) tick();
        b = rand_byte();
        model_ingest(b);
        strobe(b);
      end
      bus.ioctl_download = 1'b0;
      wait_done(exp_q.size(), 20000);
      rand_ready = 1'b0;
      compare_seq($sformatf("rand%0d_data", r));
      check($sformatf("rand%0d_overflow", r), bus.overflow, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uk101_ascii_loader.md
UK101_ASCII_LOADER -- requirements
Module: uk101_ascii_loader

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in bytes; power of two, at least 4.
REQ-002 Parameter CHAR_GAP, default 52083: idle clocks after each ordinary character.
REQ-003 Parameter CR_GAP, default 2500000: idle clocks after a CR (0x0D) character.
REQ-004 Port clk_sys  in  1  system clock. One clock domain; every flop in the block is clocked by clk_sys.
REQ-005 Port reset  in  1  reset; synchronous and active-high.
REQ-006 Port ioctl_download  in  1  file download is in progress.
REQ-007 Port ioctl_wr  in  1  one-cycle strobe; ioctl_data is valid.
REQ-008 Port ioctl_addr  in  16  byte offset in the file; informational only.
REQ-009 Port ioctl_data  in  8  file byte.
REQ-010 Port ioctl_wait  out  1  back-pressure to the HPS; registered.
REQ-011 Port enable  in  1  file load source is selected (this is ~loadFrom).
REQ-012 Port rx_data  out  8  character for the ACIA receive path.
REQ-013 Port rx_valid  out  1  rx_data is valid.
REQ-014 Port rx_ready  in  1  the consumer accepts rx_data.
REQ-015 Port busy  out  1  a load is active; drives LED_USER.
REQ-016 Port overflow  out  1  sticky flag: a byte was lost.

Function
REQ-017 Download start (rising edge of ioctl_download) SHALL flush the FIFO, clear overflow and clear the prev_cr flag in the same cycle.
REQ-018 Ingest SHALL act on ioctl_wr only while ioctl_download=1. Bytes are translated as follows:
- 0x00 and 0x1A: dropped.
- 0x0A when prev_cr=1: dropped.
- 0x0A when prev_cr=0: pushed as 0x0D.
- Any other byte: pushed unchanged.
- prev_cr SHALL be set to (byte==0x0D), evaluated on the raw byte, on every ingested strobe.
REQ-019 The FIFO SHALL use DEPTH entries with log2(DEPTH)+1-bit pointers. Full SHALL mean count==DEPTH. Empty SHALL mean count==0.
REQ-020 ioctl_wait SHALL be set to 1 on the clock after count reaches DEPTH-2 or more, and set to 0 on the clock after count falls below DEPTH-2. The two entries of headroom absorb the HPS strobe latency.
REQ-021 A push when full SHALL be discarded and SHALL set overflow=1. Count SHALL be unchanged.
REQ-022 A push and a pop in the same cycle SHALL both complete and leave count unchanged. If the FIFO was full, the push SHALL succeed.
REQ-023 Output FSM states: IDLE, PRESENT, GAP.
REQ-024 IDLE -> PRESENT when enable=1 and the FIFO is not empty. On this transition: pop one byte into rx_data, set rx_valid=1 on the next cycle.
REQ-025 In PRESENT, rx_data and rx_valid SHALL hold stable until rx_valid & rx_ready. On that cycle: rx_valid goes to 0 on the next clock, gap_cnt is loaded, the state moves to GAP.
REQ-026 gap_cnt width SHALL be at least $clog2(CR_GAP+1). It SHALL load CR_GAP-1 when rx_data==0x0D, otherwise CHAR_GAP-1.
REQ-027 GAP SHALL decrement gap_cnt each cycle and move to IDLE on the cycle gap_cnt==0. Handshake to next rx_valid SHALL be gap+2 clocks.
REQ-028 enable falling to 0 in PRESENT or GAP SHALL let the current handshake and gap complete. IDLE SHALL then hold and the FIFO SHALL retain its contents.
REQ-029 A download restart while in PRESENT or GAP SHALL flush only the FIFO. The character in flight SHALL finish normally.
REQ-030 busy SHALL be combinational: ioctl_download | ~empty | (state!=IDLE).
REQ-031 ioctl_addr SHALL have no functional effect.

Reset
REQ-032 While reset=1, every FIFO pointer, count, gap_cnt and prev_cr SHALL be set to 0, and the state SHALL be IDLE.
REQ-033 While reset=1, the outputs SHALL be rx_valid=0, rx_data=0x00, ioctl_wait=0, overflow=0.
REQ-034 Reset asserted mid-download SHALL discard all buffered data. Strobes arriving after reset deasserts SHALL be ingested only if ioctl_download is still 1.
REQ-035 No other initialisation SHALL be relied on; initial values apply only for simulation.

Verification
REQ-036 Set CHAR_GAP=4 and CR_GAP=10. Download "AB\r\n" with rx_ready=1 -> rx_data sequence 0x41, 0x42, 0x0D (only three characters); 6 clocks between the 0x41 and 0x42 rx_valid rises; 12 clocks after the CR.
REQ-037 Download "X\nY\0Z\x1A" -> output sequence 0x58, 0x0D, 0x59, 0x5A.
REQ-038 Hold rx_ready=0 and stream 20 strobes with DEPTH=16 -> ioctl_wait=1 on the clock after count reaches 14. When the source honours wait, overflow stays 0. Forcing 3 further strobes -> overflow=1 and count=16.
REQ-039 Fill the FIFO, then issue a simultaneous push and pop -> count stays 16, no overflow, and the FIFO order is preserved.
REQ-040 Hold enable=0 during the download, then raise enable -> no rx_valid before enable rises; afterwards the full buffered sequence is output in order.
REQ-041 Assert reset for 1 clock in the middle of a gap with the FIFO holding 5 bytes -> next clock: state IDLE, rx_valid=0, busy equals ioctl_download, overflow=0.
